// File: rtl/adder_op_sequencer.sv
// Handshaked operation sequencer that drives an external N-bit ripple-carry adder.
// Supports ADD, SUB, and accumulate variants. It registers the adder output together with the C/V/Z/N flags.
module adder_op_sequencer #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [N-1:0] opa,
  input  logic [N-1:0] opb,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  output logic         add_cin,
  input  logic [N-1:0] add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         flag_c,
  output logic         flag_v,
  output logic         flag_z,
  output logic         flag_n,
  output logic [N-1:0] acc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   sum_ovf;

  assign accept = (state == IDLE) && in_valid;

  // add_b already holds ~opb for subtracts, so a single rule covers both directions.
  assign sum_ovf = (add_a[N-1] == add_b[N-1]) && (add_sum[N-1] != add_a[N-1]);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      result  <= '0;
      acc     <= '0;
      flag_c  <= 1'b0;
      flag_v  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        add_a   <= op[1] ? acc : opa;
        add_b   <= op[0] ? ~opb : opb;
        add_cin <= op[0];
      end
      // The accumulator tracks every completed op, independent of the consumer.
      if (state == EXEC) begin
        result <= add_sum;
        acc    <= add_sum;
        flag_c <= add_cout;
        flag_v <= sum_ovf;
        flag_z <= (add_sum == '0);
        flag_n <= add_sum[N-1];
      end
    end
  end

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Self-checking bench for adder_op_sequencer with an ideal adder in the loop.
// It compares the DUT against a reference model written in plain integer arithmetic.
module tb_adder_op_sequencer;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [N-1:0] opa, opb;
  logic [N-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;
  logic         out_valid, out_ready;
  logic [N-1:0] result, acc;
  logic         flag_c, flag_v, flag_z, flag_n;

  int checks   = 0;
  int failures = 0;
  logic [7:0] macc = 8'h00;

  typedef struct packed {
    logic [7:0] result;
    logic       c, v, z, n;
    logic [7:0] acc;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } snap_t;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  adder_op_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .opa(opa), .opb(opb),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n),
    .acc(acc)
  );

  function automatic snap_t observe();
    snap_t s;
    s.result = result; s.c = flag_c; s.v = flag_v; s.z = flag_z; s.n = flag_n;
    s.acc = acc; s.a = add_a; s.b = add_b; s.cin = add_cin;
    return s;
  endfunction

  // Signed and unsigned arithmetic on plain ints.
  function automatic snap_t model(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] accv);
    snap_t e;
    int x, y, r, sx, sy, sr;
    x  = o[1] ? int'(accv) : int'(a);
    y  = int'(b);
    sx = (x > 127) ? x - 256 : x;
    sy = (y > 127) ? y - 256 : y;
    if (o[0]) begin
      r = x - y; sr = sx - sy; e.c = (x >= y);
    end else begin
      r = x + y; sr = sx + sy; e.c = (r > 255);
    end
    e.result = r[7:0];
    e.v      = (sr > 127) || (sr < -128);
    e.z      = (e.result == 8'h00);
    e.n      = e.result[7];
    e.acc    = e.result;
    e.a      = x[7:0];
    e.b      = o[0] ? ~b : b;
    e.cin    = o[0];
    return e;
  endfunction

  // Issue one op, wait (bounded) for out_valid, snapshot, then complete the handshake.
  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        output snap_t s, output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; opa = a; opb = b; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; op = 2'($urandom); opa = 8'($urandom); opb = 8'($urandom);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    s = observe();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    macc = 8'h00;
  endtask

  task automatic test_reset();
    snap_t s;
    rst = 1'b1; in_valid = 1'b1; op = 2'b00; opa = 8'h11; opb = 8'h22; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold in_ready=%b out_valid=%b required 0 0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    s = observe();
    checks++;
    if (s !== '0) begin
      failures++;
      $display("FAIL reset_values got=%h required=0", s);
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    macc = 8'h00;
  endtask

  task automatic test_add();
    logic [7:0] va [4] = '{8'h7F, 8'hFF, 8'h00, 8'h80};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h00, 8'h80};
    snap_t s, e;
    int lat;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, b;
      a = (i < 4) ? va[i] : 8'($urandom);
      b = (i < 4) ? vb[i] : 8'($urandom);
      e = model(2'b00, a, b, macc);
      run_op(2'b00, a, b, s, lat);
      macc = e.acc;
      checks++;
      if (lat !== 2) begin
        failures++;
        $display("FAIL add_latency op%0d got=%0d required=2", i, lat);
      end
      checks++;
      if (s !== e) begin
        failures++;
        $display("FAIL add_result %h+%h got=%h required=%h", a, b, s, e);
      end
    end
  endtask

  task automatic test_sub();
    logic [7:0] va [4] = '{8'h05, 8'h03, 8'h80, 8'h00};
    logic [7:0] vb [4] = '{8'h05, 8'h05, 8'h01, 8'h80};
    snap_t s, e;
    int lat;
    for (int i = 0; i < 12; i++) begin
      logic [7:0] a, b;
      a = (i < 4) ? va[i] : 8'($urandom);
      b = (i < 4) ? vb[i] : 8'($urandom);
      e = model(2'b01, a, b, macc);
      run_op(2'b01, a, b, s, lat);
      macc = e.acc;
      checks++;
      if (lat !== 2 || s !== e) begin
        failures++;
        $display("FAIL sub_result %h-%h lat=%0d got=%h required=%h", a, b, lat, s, e);
      end
    end
  endtask

  task automatic test_acc();
    logic [1:0] vo [3] = '{2'b10, 2'b10, 2'b11};
    logic [7:0] vb [3] = '{8'hFF, 8'h01, 8'h01};
    snap_t s, e;
    int lat;
    pulse_reset();
    for (int i = 0; i < 15; i++) begin
      logic [1:0] o;
      logic [7:0] a, b;
      o = (i < 3) ? vo[i] : {1'b1, 1'($urandom)};
      a = 8'($urandom);
      b = (i < 3) ? vb[i] : 8'($urandom);
      e = model(o, a, b, macc);
      run_op(o, a, b, s, lat);
      macc = e.acc;
      checks++;
      if (lat !== 2 || s !== e) begin
        failures++;
        $display("FAIL acc_result op=%b b=%h lat=%0d got=%h required=%h", o, b, lat, s, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    snap_t s, e;
    int lat;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] o;
      logic [7:0] a, b;
      o = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
      e = model(o, a, b, macc);
      run_op(o, a, b, s, lat);
      macc = e.acc;
      checks++;
      if (lat !== 2 || s !== e) begin
        failures++;
        $display("FAIL mix_result op=%b a=%h b=%h lat=%0d got=%h required=%h", o, a, b, lat, s, e);
      end
    end
  endtask

  task automatic test_backpressure();
    snap_t s, e, e2;
    e = model(2'b00, 8'h3C, 8'h42, macc);
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; opa = 8'h3C; opb = 8'h42; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    macc = e.acc;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); op = 2'($urandom); opa = 8'($urandom); opb = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      s = observe();
      checks++;
      if (s !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cyc%0d got=%h ov=%b ir=%b required=%h ov=1 ir=0",
                 i, s, out_valid, in_ready, e);
      end
    end
    in_valid = 1'b1; op = 2'b01; opa = 8'h09; opb = 8'h04; out_ready = 1'b1;
    e2 = model(2'b01, 8'h09, 8'h04, macc);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    s = observe();
    checks++;
    if (s !== e2 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL stall_next_op got=%h ov=%b required=%h ov=1", s, out_valid, e2);
    end
    macc = e2.acc;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    snap_t s, e;
    int lat;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; opa = 8'h10; opb = 8'h20; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    macc = 8'h00;
    #1;
    checks++;
    if (out_valid !== 1'b0 || acc !== 8'h00 || result !== 8'h00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_state ov=%b acc=%h res=%h ir=%b required 0 00 00 1",
               out_valid, acc, result, in_ready);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midrst_no_valid pulses=%0d required=0", seen);
    end
    e = model(2'b00, 8'h01, 8'h01, macc);
    run_op(2'b00, 8'h01, 8'h01, s, lat);
    macc = e.acc;
    checks++;
    if (lat !== 2 || s.result !== 8'h02 || s !== e) begin
      failures++;
      $display("FAIL midrst_follow lat=%0d got=%h required=%h", lat, s, e);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout elapsed=%0t required finish before", $time);
    $fatal(1);
  end
endmodule
